// File: rtl/tetris_pkg.sv
// Shared Tetris constants: command codes, PS/2 scancodes, receiver state type.
// Pure declarations; no latency or backpressure of its own.
package tetris_pkg;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_ROTATE = 3'd3;
  localparam logic [2:0] CMD_SOFT   = 3'd4;
  localparam logic [2:0] CMD_HARD   = 3'd5;
  localparam logic [2:0] CMD_PAUSE  = 3'd6;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_SOFT   = 8'h72;
  localparam logic [7:0] SC_HARD   = 8'h29;
  localparam logic [7:0] SC_PAUSE  = 8'h4D;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} ps2_state_t;

  // CMD_NONE marks an unmapped code; extended and plain forms map alike.
  function automatic logic [2:0] sc_to_cmd(input logic [7:0] sc);
    logic [2:0] cmd;
    case (sc)
      SC_LEFT:   cmd = CMD_LEFT;
      SC_RIGHT:  cmd = CMD_RIGHT;
      SC_ROTATE: cmd = CMD_ROTATE;
      SC_SOFT:   cmd = CMD_SOFT;
      SC_HARD:   cmd = CMD_HARD;
      SC_PAUSE:  cmd = CMD_PAUSE;
      default:   cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/ps2_cmd_input_if.sv
// Command-side bus between the keyboard front end and the processor.
// master = processor (pops), slave = ps2_cmd_input (produces).
interface ps2_cmd_input_if;
  logic       cmd_rd;
  logic       cmd_valid;
  logic [2:0] cmd_data;
  logic       frame_err;
  logic       overflow;

  modport master (output cmd_rd, input cmd_valid, cmd_data, frame_err, overflow);
  modport slave  (input cmd_rd, output cmd_valid, cmd_data, frame_err, overflow);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, framing FSM, timeout.
// byte_valid/rx_err one cycle after the stop/failing fe; no backpressure.
module ps2_rx
  import tetris_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          fe, data_bit;

  assign fe       = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;
    tmo_d        = (state_q == IDLE || fe) ? '0 : tmo_q + TW'(1);
    if (fe) begin
      case (state_q)
        IDLE: if (!data_bit) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
        SHIFT: begin
          shift_d   = {data_bit, shift_q[7:1]};
          par_d     = par_q ^ data_bit;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          // Data plus parity must carry an odd number of ones.
          if (par_q ^ data_bit) state_d = STOP;
          else begin
            state_d  = IDLE;
            rx_err_d = 1'b1;
          end
        end
        STOP: begin
          state_d      = IDLE;
          byte_valid_d = data_bit;
          rx_err_d     = ~data_bit;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d  = IDLE;
      rx_err_d = 1'b1;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q   <= 3'b111;
      data_sync_q  <= 2'b11;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign rx_err     = rx_err_q;

endmodule

// File: rtl/ps2_cmd_input.sv
// PS/2 keyboard front end: decodes game make codes into 3-bit commands in a show-ahead FIFO.
// Command visible 2 cycles after the stop-bit fe; full FIFO drops new commands and sets sticky overflow.
module ps2_cmd_input
  import tetris_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_cmd_input_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       byte_valid, rx_err;
  logic [7:0] byte_data;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .rx_err     (rx_err)
  );

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [2:0]    mem_d [FIFO_DEPTH];
  logic          ovf_q, ovf_d;
  logic [2:0]    push_cmd;
  logic          push, pop, empty, full;

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    push     = 1'b0;
    push_cmd = sc_to_cmd(byte_data);
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (byte_data == SC_E0)      ext_d = 1'b1;
      else if (byte_data == SC_F0) brk_d = 1'b1;
      else begin
        push  = !brk_q && (push_cmd != CMD_NONE);
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = bus.cmd_rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    ovf_d    = ovf_q;
    if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    // A simultaneous pop frees the slot the push lands in.
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_cmd;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.cmd_valid = !empty;
  assign bus.cmd_data  = empty ? CMD_NONE : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.frame_err = rx_err;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_cmd_input.sv
// Directed bench for ps2_cmd_input: bit-banged PS/2 frames, expected commands queued and
// compared as the processor side drains them.
module tb_ps2_cmd_input;

  localparam int TMO = 400;  // short timeout keeps the run small
  localparam int HP  = 10;   // PS/2 half period in iCLK cycles

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_cmd_input_if bus();

  ps2_cmd_input #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int fails = 0;
  int err_hi = 0;
  int err_pulses = 0;
  logic err_prev = 1'b0;
  logic [2:0] exp_q[$];

  always @(negedge iCLK) begin
    if (bus.frame_err && !err_prev) err_pulses++;
    if (bus.frame_err) err_hi++;
    err_prev = bus.frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HP);
    ps2_clk = 1'b0;
    cyc(HP);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check first-command latency; 2: pop in the FIFO write cycle
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
    logic [9:0] bits;
    logic [2:0] e;
    bits = {(~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2_data = 1'b1;
    cyc(HP);
    ps2_clk = 1'b0;
    // pin edge -> 2 sync flops -> fe cycle; byte_valid next; FIFO write on the edge after
    if (mode == 1) begin
      cyc(3);
      chk("lat_valid_early", bus.cmd_valid, 1'b0);
      cyc(1);
      chk("lat_valid", bus.cmd_valid, 1'b1);
      cyc(HP - 4);
    end else if (mode == 2) begin
      cyc(3);
      e = 3'd7;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("simul_head", bus.cmd_data, e);
      bus.cmd_rd = 1'b1;
      cyc(1);
      bus.cmd_rd = 1'b0;
      cyc(HP - 4);
    end else begin
      cyc(HP);
    end
    ps2_clk = 1'b1;
    cyc(HP);
  endtask

  task automatic pop_chk(input string tag);
    int n;
    logic [2:0] e;
    n = 0;
    while (!bus.cmd_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk({tag, "_valid"}, bus.cmd_valid, 1'b1);
    e = 3'd7;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_data"}, bus.cmd_data, e);
    bus.cmd_rd = 1'b1;
    cyc(1);
    bus.cmd_rd = 1'b0;
  endtask

  initial begin
    int p0, h0;
    logic [7:0] pb;
    bus.cmd_rd = 1'b0;
    cyc(3);
    chk("rst_valid", bus.cmd_valid, 1'b0);
    chk("rst_data", bus.cmd_data, 3'd0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    iRST_n = 1'b1;
    cyc(5);

    // single press
    exp_q.push_back(3'd1);
    send_frame(8'h6B, 1'b0, 1);
    pop_chk("left");
    chk("left_drained", bus.cmd_valid, 1'b0);

    // extended press, extended release, unmapped key, plain release
    send_frame(8'hE0, 1'b0, 0);
    exp_q.push_back(3'd3);
    send_frame(8'h75, 1'b0, 0);
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h75, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h6B, 1'b0, 0);
    pop_chk("rotate");
    chk("rotate_only", bus.cmd_valid, 1'b0);

    // parity error then good frame
    p0 = err_pulses;
    h0 = err_hi;
    send_frame(8'h74, 1'b1, 0);
    chk("par_pulse", err_pulses - p0, 1);
    chk("par_width", err_hi - h0, 1);
    chk("par_nopush", bus.cmd_valid, 1'b0);
    exp_q.push_back(3'd2);
    send_frame(8'h74, 1'b0, 0);
    pop_chk("right");

    // timeout after 4 data bits
    p0 = err_pulses;
    pb = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(pb[i]);
    cyc(TMO + 2 - HP);
    chk("tmo_early", bus.frame_err, 1'b0);
    cyc(1);
    chk("tmo_pulse", bus.frame_err, 1'b1);
    cyc(1);
    chk("tmo_end", bus.frame_err, 1'b0);
    chk("tmo_count", err_pulses - p0, 1);
    exp_q.push_back(3'd5);
    send_frame(8'h29, 1'b0, 0);
    pop_chk("hard");
    chk("hard_drained", bus.cmd_valid, 1'b0);

    // overflow: 5 pushes, 4 slots
    exp_q.push_back(3'd1); send_frame(8'h6B, 1'b0, 0);
    exp_q.push_back(3'd2); send_frame(8'h74, 1'b0, 0);
    exp_q.push_back(3'd3); send_frame(8'h75, 1'b0, 0);
    exp_q.push_back(3'd4); send_frame(8'h72, 1'b0, 0);
    chk("full_no_ovf", bus.overflow, 1'b0);
    send_frame(8'h29, 1'b0, 0);
    chk("ovf_set", bus.overflow, 1'b1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_order");
    chk("ovf_drained", bus.cmd_valid, 1'b0);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // reset mid-frame with a command queued
    send_frame(8'h6B, 1'b0, 0);
    chk("pre_rst_valid", bus.cmd_valid, 1'b1);
    pb = 8'h72;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(pb[i]);
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.cmd_valid, 1'b0);
    chk("mid_rst_data", bus.cmd_data, 3'd0);
    chk("mid_rst_ferr", bus.frame_err, 1'b0);
    chk("mid_rst_ovf", bus.overflow, 1'b0);
    ps2_data = 1'b1;
    cyc(2);
    iRST_n = 1'b1;
    cyc(5);
    exp_q.push_back(3'd4);
    send_frame(8'h72, 1'b0, 0);
    pop_chk("soft");
    chk("soft_drained", bus.cmd_valid, 1'b0);

    // full FIFO: push and pop in the same cycle
    exp_q.push_back(3'd1); send_frame(8'h6B, 1'b0, 0);
    exp_q.push_back(3'd2); send_frame(8'h74, 1'b0, 0);
    exp_q.push_back(3'd3); send_frame(8'h75, 1'b0, 0);
    exp_q.push_back(3'd4); send_frame(8'h72, 1'b0, 0);
    exp_q.push_back(3'd6);
    send_frame(8'h4D, 1'b0, 2);
    chk("simul_no_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 4; i++) pop_chk("simul_order");
    chk("simul_drained", bus.cmd_valid, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
